// File: rtl/pc_stack_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_stack_reg
// Brief    : Program-counter register with load/incr/branch and a LIFO
//            return-address stack for call/return, sticky over/underflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module pc_stack_reg #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int STEP  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 ctrl,
  input  logic [N-1:0]               in,
  output logic [N-1:0]               out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int CW      = $clog2(DEPTH + 1);
  localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_SLOTS = 1 << IW;

  localparam logic [2:0] c_OP_HOLD   = 3'b000;
  localparam logic [2:0] c_OP_LOAD   = 3'b001;
  localparam logic [2:0] c_OP_INCR   = 3'b010;
  localparam logic [2:0] c_OP_CLEAR  = 3'b011;
  localparam logic [2:0] c_OP_BRANCH = 3'b100;
  localparam logic [2:0] c_OP_CALL   = 3'b101;
  localparam logic [2:0] c_OP_RETURN = 3'b110;
  localparam logic [2:0] c_OP_FLUSH  = 3'b111;

  localparam logic [N-1:0]  c_STEP  = N'(STEP);
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] c_ONE   = CW'(1);

  // Power-up values match the reset values so out reads 0 before any rst.
  logic [N-1:0]  r_out   = '0;
  logic [CW-1:0] r_count = '0;
  logic          r_err   = 1'b0;
  logic [N-1:0]  r_stack [c_SLOTS];

  logic          w_full;
  logic          w_empty;
  logic [N-1:0]  w_ret_addr;
  logic [IW-1:0] w_push_idx;
  logic [IW-1:0] w_pop_idx;
  logic [CW-1:0] w_count_dec;

  assign w_full      = (r_count == c_DEPTH);
  assign w_empty     = (r_count == '0);
  assign w_ret_addr  = r_out + c_STEP;
  assign w_count_dec = r_count - c_ONE;
  assign w_push_idx  = r_count[IW-1:0];
  assign w_pop_idx   = w_count_dec[IW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (ctrl)
        c_OP_HOLD:   ;
        c_OP_LOAD:   r_out <= in;
        c_OP_INCR:   r_out <= r_out + c_STEP;
        c_OP_CLEAR:  r_out <= '0;
        c_OP_BRANCH: r_out <= r_out + in;  // modular add == signed offset add
        c_OP_CALL: begin
          if (w_full) begin
            r_err <= 1'b1;
          end else begin
            r_out   <= in;
            r_count <= r_count + c_ONE;
          end
        end
        c_OP_RETURN: begin
          if (w_empty) begin
            r_err <= 1'b1;
          end else begin
            r_out   <= r_stack[w_pop_idx];
            r_count <= w_count_dec;
          end
        end
        c_OP_FLUSH: begin
          r_count <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Stack storage carries no reset; entries above count are never read.
  always_ff @(posedge clk) begin
    if (!rst && (ctrl == c_OP_CALL) && !w_full) begin
      r_stack[w_push_idx] <= w_ret_addr;
    end
  end

  assign out   = r_out;
  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;
  assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_stack_reg
// Brief    : Directed and randomized self-checking bench for pc_stack_reg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_stack_reg;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int STEP  = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    ctrl = 3'b000;
  logic [N-1:0]  in = '0;
  logic [N-1:0]  out;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          err;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: PC value, return stack as a queue, sticky error bit.
  int m_out = 0;
  int m_stk[$];
  bit m_err = 1'b0;

  pc_stack_reg #(.N(N), .DEPTH(DEPTH), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .in(in),
    .out(out), .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [2:0] c, input logic [N-1:0] d);
    int t;
    rst = r; ctrl = c; in = d;
    @(posedge clk);
    #1;
    if (r) begin
      m_out = 0; m_stk.delete(); m_err = 1'b0;
    end else begin
      case (c)
        3'd1: m_out = d;
        3'd2: m_out = (m_out + STEP) % (1 << N);
        3'd3: m_out = 0;
        3'd4: begin
          t = m_out + int'($signed(d));
          m_out = t & ((1 << N) - 1);
        end
        3'd5: begin
          if (m_stk.size() == DEPTH) m_err = 1'b1;
          else begin
            m_stk.push_back((m_out + STEP) % (1 << N));
            m_out = d;
          end
        end
        3'd6: begin
          if (m_stk.size() == 0) m_err = 1'b1;
          else m_out = m_stk.pop_back();
        end
        3'd7: begin
          m_stk.delete(); m_err = 1'b0;
        end
        default: ;
      endcase
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if (out !== 8'h00) $display("FAIL powerup_out: got %h want 00", out); else n_pass++;
    step(1'b1, 3'b001, 8'hAA);
    n_total++;
    if (out !== 8'h00) $display("FAIL reset_out: got %h want 00", out); else n_pass++;
    n_total++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_flags: count=%0d empty=%b full=%b err=%b want 0/1/0/0", count, empty, full, err);
    else n_pass++;
  endtask

  task automatic test_incr_wrap();
    logic [7:0] exp_v [3];
    exp_v[0] = 8'hFF; exp_v[1] = 8'h00; exp_v[2] = 8'h01;
    step(1'b1, 3'b000, 8'h00);
    step(1'b0, 3'b001, 8'hFE);
    n_total++;
    if (out !== 8'hFE) $display("FAIL load: got %h want fe", out); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b010, 8'h00);
      n_total++;
      if (out !== exp_v[i]) $display("FAIL incr_%0d: got %h want %h", i, out, exp_v[i]); else n_pass++;
    end
    step(1'b0, 3'b000, 8'h99);
    n_total++;
    if (out !== 8'h01) $display("FAIL hold: got %h want 01", out); else n_pass++;
    step(1'b0, 3'b011, 8'h99);
    n_total++;
    if (out !== 8'h00) $display("FAIL clear: got %h want 00", out); else n_pass++;
  endtask

  task automatic test_branch();
    step(1'b0, 3'b001, 8'h10);
    step(1'b0, 3'b100, 8'hFC);
    n_total++;
    if (out !== 8'h0C) $display("FAIL branch_back: got %h want 0c", out); else n_pass++;
    step(1'b0, 3'b100, 8'h05);
    n_total++;
    if (out !== 8'h11) $display("FAIL branch_fwd: got %h want 11", out); else n_pass++;
  endtask

  task automatic test_call_return();
    logic [2:0] ops   [4];
    logic [7:0] ins   [4];
    logic [7:0] exp_o [4];
    logic [2:0] exp_c [4];
    ops[0] = 3'b101; ins[0] = 8'h40; exp_o[0] = 8'h40; exp_c[0] = 3'd1;
    ops[1] = 3'b101; ins[1] = 8'h60; exp_o[1] = 8'h60; exp_c[1] = 3'd2;
    ops[2] = 3'b110; ins[2] = 8'h00; exp_o[2] = 8'h41; exp_c[2] = 3'd1;
    ops[3] = 3'b110; ins[3] = 8'h00; exp_o[3] = 8'h21; exp_c[3] = 3'd0;
    step(1'b1, 3'b000, 8'h00);
    step(1'b0, 3'b001, 8'h20);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, ops[i], ins[i]);
      n_total++;
      if (out !== exp_o[i] || count !== exp_c[i])
        $display("FAIL callret_%0d: out=%h count=%0d want out=%h count=%0d", i, out, count, exp_o[i], exp_c[i]);
      else n_pass++;
    end
    n_total++;
    if (empty !== 1'b1 || err !== 1'b0) $display("FAIL callret_end: empty=%b err=%b want 1/0", empty, err); else n_pass++;
  endtask

  task automatic test_overflow_flush();
    step(1'b1, 3'b000, 8'h00);
    step(1'b0, 3'b001, 8'h05);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 3'b101, 8'(i * 16));
      n_total++;
      if (count !== 3'(i) || out !== 8'(i * 16) || full !== (i == 4))
        $display("FAIL fill_%0d: count=%0d out=%h full=%b want %0d/%h/%b", i, count, out, full, i, 8'(i * 16), (i == 4));
      else n_pass++;
    end
    step(1'b0, 3'b101, 8'h50);
    n_total++;
    if (out !== 8'h40 || count !== 3'd4 || err !== 1'b1)
      $display("FAIL overflow: out=%h count=%0d err=%b want 40/4/1", out, count, err);
    else n_pass++;
    step(1'b0, 3'b111, 8'h00);
    n_total++;
    if (out !== 8'h40 || count !== 3'd0 || err !== 1'b0 || empty !== 1'b1)
      $display("FAIL flush: out=%h count=%0d err=%b empty=%b want 40/0/0/1", out, count, err, empty);
    else n_pass++;
  endtask

  task automatic test_underflow_err();
    step(1'b1, 3'b000, 8'h00);
    step(1'b0, 3'b001, 8'h33);
    step(1'b0, 3'b110, 8'h00);
    n_total++;
    if (out !== 8'h33 || count !== 3'd0 || err !== 1'b1)
      $display("FAIL underflow: out=%h count=%0d err=%b want 33/0/1", out, count, err);
    else n_pass++;
    step(1'b0, 3'b010, 8'h00);
    n_total++;
    if (out !== 8'h34 || err !== 1'b1) $display("FAIL err_sticky: out=%h err=%b want 34/1", out, err); else n_pass++;
    step(1'b1, 3'b101, 8'h77);
    n_total++;
    if (out !== 8'h00 || count !== 3'd0 || err !== 1'b0)
      $display("FAIL rst_priority: out=%h count=%0d err=%b want 00/0/0", out, count, err);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] exp_out;
    logic [2:0] exp_cnt;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      exp_out = m_out[7:0];
      exp_cnt = 3'(m_stk.size());
      n_total++;
      if (out !== exp_out || count !== exp_cnt || err !== m_err ||
          full !== (m_stk.size() == DEPTH) || empty !== (m_stk.size() == 0))
        $display("FAIL random_%0d: out=%h count=%0d err=%b full=%b empty=%b want out=%h count=%0d err=%b",
                 i, out, count, err, full, empty, exp_out, exp_cnt, m_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_incr_wrap();
    test_branch();
    test_call_return();
    test_overflow_flush();
    test_underflow_err();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
